// File: rtl/sample_serial_pkg.sv
// Shared definitions for the 1-bit sampled serial link (transmitter and receiver).
// Frame: start, data LSB-first, optional parity (SAMPLE_SERIAL_TX_PARITY_EN), stop.
package sample_serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

   // clog2 that never returns 0, so a counter of a 1-value range still has a bit
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sample_bit_timer.sv
// Phase counter for one serial bit: counts 0..BIT_CYCLES-1, tick on the last phase.
module sample_bit_timer
   import sample_serial_pkg::*;
#(
   parameter int BIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int PW = cnt_w(BIT_CYCLES);
   localparam logic [PW-1:0] LAST = PW'(BIT_CYCLES - 1);

   logic [PW-1:0] phase;

   assign tick = (phase == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase <= '0;
      end else if (clear || tick) begin
         phase <= '0;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/sample_serial_tx.sv
// Serial transmitter: start, data LSB-first, optional even parity, stop; each bit held
// BIT_CYCLES clocks. Parity bit is built only when SAMPLE_SERIAL_TX_PARITY_EN is defined.
module sample_serial_tx
   import sample_serial_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              out,
   output logic              busy,
   output state_t            state
);

   localparam int BW = cnt_w(DATA_W + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              out_q, out_d;
   logic              tick;
   logic              accept;
`ifdef SAMPLE_SERIAL_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   sample_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clear (state_q == IDLE),
      .tick  (tick)
   );

   // Handshake: a word transfers on any posedge with tx_valid && tx_ready; tx_ready
   // never depends on tx_valid, and the producer holds tx_data/tx_valid until then.
   assign tx_ready = (state_q == IDLE) || ((state_q == STOP) && tick);
   assign accept   = tx_valid && tx_ready;
   assign busy     = (state_q != IDLE);
   assign out      = out_q;
   assign state    = state_q;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bit_d   = bit_q;
`ifdef SAMPLE_SERIAL_TX_PARITY_EN
      parity_d = parity_q;
      if (accept) parity_d = ^tx_data;
`endif
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               shift_d = tx_data;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               bit_d   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_q == LAST_BIT) begin
`ifdef SAMPLE_SERIAL_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef SAMPLE_SERIAL_TX_PARITY_EN
         PARITY: begin
            if (tick) state_d = STOP;
         end
`endif
         STOP: begin
            if (tick) begin
               if (accept) begin
                  state_d = START;
                  shift_d = tx_data;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so out is a flop aligned with state_q
   always_comb begin
      out_d = LINE_IDLE;
      case (state_d)
         IDLE:   out_d = LINE_IDLE;
         START:  out_d = LINE_START;
         DATA:   out_d = shift_d[0];
`ifdef SAMPLE_SERIAL_TX_PARITY_EN
         PARITY: out_d = parity_d;
`endif
         STOP:   out_d = LINE_STOP;
         default: out_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bit_q   <= '0;
         out_q   <= LINE_IDLE;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         out_q   <= out_d;
      end
   end

`ifdef SAMPLE_SERIAL_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) parity_q <= 1'b0;
      else      parity_q <= parity_d;
   end
`endif

endmodule

// File: tb/tb_sample_serial_tx.sv
// Directed bench for sample_serial_tx (BIT_CYCLES=2 and BIT_CYCLES=1 instances);
// parity expectations follow SAMPLE_SERIAL_TX_PARITY_EN.
module tb_sample_serial_tx;
   import sample_serial_pkg::*;

`ifdef SAMPLE_SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int BC   = 2;
   localparam int FLEN = (8 + 2 + PAR) * BC;
   localparam int FLEN1 = (8 + 2 + PAR);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = '0;
   logic       tx_valid = 1'b0;
   logic       tx_ready, out, busy;
   state_t     state;
   logic [7:0] tx_data1 = '0;
   logic       tx_valid1 = 1'b0;
   logic       tx_ready1, out1, busy1;
   state_t     state1;

   int checks = 0;
   int failures = 0;
   logic [0:0] exp_q[$];

   always #5 clk = ~clk;

   sample_serial_tx #(.DATA_W(8), .BIT_CYCLES(BC)) u_dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .out(out), .busy(busy), .state(state)
   );

   sample_serial_tx #(.DATA_W(8), .BIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1),
      .tx_ready(tx_ready1), .out(out1), .busy(busy1), .state(state1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [7:0] d, input int bc);
      for (int c = 0; c < bc; c++) exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++)
         for (int c = 0; c < bc; c++) exp_q.push_back(d[j]);
      if (PAR == 1)
         for (int c = 0; c < bc; c++) exp_q.push_back(^d);
      for (int c = 0; c < bc; c++) exp_q.push_back(1'b1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_out"}, out, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, tx_ready, 1);
      chk({tag, "_state"}, state, IDLE);
   endtask

   // n frames (1 or 2, back-to-back); abort_at >= 0 pulses reset at that frame cycle
   task automatic run(input string tag, input int n, input logic [7:0] d0,
                      input logic [7:0] d1, input int abort_at);
      logic [7:0] w[2];
      logic       seen[$];
      logic [0:0] e;
      logic [7:0] rec;
      w[0] = d0;
      w[1] = d1;
      exp_q.delete();
      for (int k = 0; k < n; k++) push_frame(w[k], BC);
      chk({tag, "_ready_pre"}, tx_ready, 1);
      tx_data  = d0;
      tx_valid = 1'b1;
      step();
      if (n == 1) tx_valid = 1'b0;
      for (int i = 0; i < n * FLEN; i++) begin
         if (i == abort_at) begin
            rst = 1'b0;
            #1;
            chk_idle({tag, "_abort"});
            step();
            rst = 1'b1;
            step();
            chk_idle({tag, "_after_abort"});
            exp_q.delete();
            return;
         end
         e = exp_q.pop_front();
         chk($sformatf("%s_out%0d", tag, i), out, e);
         chk($sformatf("%s_ready%0d", tag, i), tx_ready, ((i % FLEN) == FLEN - 1));
         chk($sformatf("%s_busy%0d", tag, i), busy, 1);
         seen.push_back(out);
         tx_data = 8'($urandom_range(0, 255));
         if (n == 2 && i == FLEN - 1) tx_data = d1;
         if (n == 2 && i == FLEN) tx_valid = 1'b0;
         step();
      end
      chk_idle({tag, "_end"});
      // Half-rate receiver view: sample the second clock of each bit
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 8; j++) rec[j] = seen[k * FLEN + (1 + j) * BC + BC - 1];
         chk($sformatf("%s_rx%0d", tag, k), rec, w[k]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [0:0] e;
      // reset state
      step();
      chk_idle("reset");
      chk("reset_out1", out1, 1);
      chk("reset_ready1", tx_ready1, 1);
      rst = 1'b1;
      step();

      // idle with tx_valid low: no spurious start
      for (int i = 0; i < 50; i++) begin
         tx_data = 8'($urandom_range(0, 255));
         chk($sformatf("idle_out%0d", i), out, 1);
         chk($sformatf("idle_busy%0d", i), busy, 0);
         chk($sformatf("idle_ready%0d", i), tx_ready, 1);
         step();
      end

      // single frames, tx_data scrambled mid-frame
      run("a5", 1, 8'hA5, 8'h00, -1);
      run("07", 1, 8'h07, 8'h00, -1);
      // back-to-back with tx_valid held high
      run("b2b", 2, 8'h00, 8'hFF, -1);
      // reset during data bit 3 (frame cycles 8..9)
      run("abort", 1, 8'h3C, 8'h00, 8);
      run("81", 1, 8'h81, 8'h00, -1);

      // one bit per clock
      exp_q.delete();
      push_frame(8'h01, 1);
      chk("bc1_ready_pre", tx_ready1, 1);
      tx_data1  = 8'h01;
      tx_valid1 = 1'b1;
      step();
      tx_valid1 = 1'b0;
      for (int i = 0; i < FLEN1; i++) begin
         e = exp_q.pop_front();
         chk($sformatf("bc1_out%0d", i), out1, e);
         chk($sformatf("bc1_ready%0d", i), tx_ready1, (i == FLEN1 - 1));
         chk($sformatf("bc1_busy%0d", i), busy1, 1);
         tx_data1 = 8'($urandom_range(0, 255));
         step();
      end
      chk("bc1_end_out", out1, 1);
      chk("bc1_end_busy", busy1, 0);
      chk("bc1_end_state", state1, IDLE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
